// File: rtl/gcd_driver_if.sv
// Bundle of client-side job signals and GCD-unit 4-phase handshake signals.
// slave: the driver's view. master: the environment's view (client plus GCD unit).
interface gcd_driver_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c;
  logic        out_err;
  logic        req;
  logic        ack;
  logic [15:0] AB;
  logic [15:0] C;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, ack, C,
    output in_ready, out_valid, out_c, out_err, req, AB
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, ack, C,
    input  in_ready, out_valid, out_c, out_err, req, AB
  );
endinterface

// File: rtl/gcd_driver.sv
// gcd_driver: accepts one job from a local client, ships both operands to an
// external GCD unit over a 4-phase req/ack handshake, and holds the result
// until the client takes it. Zero operands are answered locally.
// Optional macro GCD_DRV_TIMEOUT_EN adds a wait-state watchdog that aborts a
// stuck handshake after TIMEOUT_CYCLES cycles and flags out_err.
//
// state  | meaning
// IDLE   | ready for a job, bus quiet
// SEND_A | req high, AB = reg_a, waiting for ack
// REL_A  | req low, waiting for ack to drop
// SEND_B | req high, AB = reg_b, waiting for ack with result on C
// REL_B  | req low, waiting for ack to drop
// DONE   | result presented until the client consumes it
module gcd_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         reset,
  gcd_driver_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEND_A, REL_A, SEND_B, REL_B, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] reg_a, reg_b, res_c;
  logic        load_op, load_zero, load_c, load_tmo;
  logic        waiting;
  logic        tmo;

  assign waiting = (state == SEND_A) || (state == REL_A) ||
                   (state == SEND_B) || (state == REL_B);

`ifdef GCD_DRV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             res_err;

  // Wait-cycle counter: restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (waiting)            cnt <= cnt + CNT_W'(1);
  end

  // Fires on the last permitted cycle so req is high for exactly TIMEOUT_CYCLES.
  assign tmo = waiting && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error flag travels with the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    res_err <= 1'b0;
    else if (load_zero || load_c) res_err <= 1'b0;
    else if (load_tmo)            res_err <= 1'b1;
  end

  assign bus.out_err = res_err;
`else
  assign tmo         = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and register-load decode; ack beats timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    load_zero = 1'b0;
    load_c    = 1'b0;
    load_tmo  = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        load_op = 1'b1;
        if (bus.in_a != 16'd0 && bus.in_b != 16'd0) begin
          state_nxt = SEND_A;
        end else begin
          load_zero = 1'b1;
          state_nxt = DONE;
        end
      end
      SEND_A: if (bus.ack)    state_nxt = REL_A;
              else if (tmo) begin load_tmo = 1'b1; state_nxt = DONE; end
      REL_A:  if (!bus.ack)   state_nxt = SEND_B;
              else if (tmo) begin load_tmo = 1'b1; state_nxt = DONE; end
      SEND_B: if (bus.ack) begin load_c = 1'b1; state_nxt = REL_B; end
              else if (tmo) begin load_tmo = 1'b1; state_nxt = DONE; end
      REL_B:  if (!bus.ack)   state_nxt = DONE;
              else if (tmo) begin load_tmo = 1'b1; state_nxt = DONE; end
      DONE:   if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a <= 16'd0;
      reg_b <= 16'd0;
      res_c <= 16'd0;
    end else begin
      if (load_op) begin
        reg_a <= bus.in_a;
        reg_b <= bus.in_b;
      end
      if (load_zero)     res_c <= (bus.in_a == 16'd0) ? bus.in_b : bus.in_a;
      else if (load_c)   res_c <= bus.C;
      else if (load_tmo) res_c <= 16'd0;
    end
  end

  // Moore outputs; AB follows reg_b from REL_A onward so it never moves under req.
  always_comb begin
    case (state)
      SEND_A:               bus.AB = reg_a;
      REL_A, SEND_B, REL_B: bus.AB = reg_b;
      default:              bus.AB = 16'd0;
    endcase
  end

  assign bus.req       = (state == SEND_A) || (state == SEND_B);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_c     = res_c;

endmodule

// File: tb/tb_gcd_driver.sv
// Self-checking bench for gcd_driver: behavioural 4-phase GCD responder with
// random ack latency, protocol monitor, and Euclid reference model.
module tb_gcd_driver;
  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  gcd_driver_if ifc ();

  gcd_driver #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural GCD unit
  int          rs;
  int          rdly;
  int          max_dly = 2;
  bit          never_ack = 0;
  bit          stall_b = 0;
  logic [15:0] ra, rb;
  logic [15:0] ab_q[$];

  always @(posedge clk or posedge reset) begin
    int d;
    if (reset) begin
      rs      <= 0;
      rdly    <= 0;
      ifc.ack <= 1'b0;
      ifc.C   <= 16'd0;
    end else begin
      case (rs)
        0: if (ifc.req && !never_ack) begin
          ra <= ifc.AB;
          ab_q.push_back(ifc.AB);
          d = $urandom_range(0, max_dly);
          if (d == 0) begin ifc.ack <= 1'b1; rs <= 2; rdly <= $urandom_range(0, max_dly); end
          else begin rs <= 1; rdly <= d - 1; end
        end
        1: if (rdly == 0) begin ifc.ack <= 1'b1; rs <= 2; rdly <= $urandom_range(0, max_dly); end
           else rdly <= rdly - 1;
        2: if (!ifc.req) begin
          if (rdly == 0) begin ifc.ack <= 1'b0; rs <= 3; end
          else rdly <= rdly - 1;
        end
        3: if (ifc.req && !stall_b) begin
          rb <= ifc.AB;
          ab_q.push_back(ifc.AB);
          d = $urandom_range(0, max_dly);
          if (d == 0) begin
            ifc.C <= ref_gcd(ra, ifc.AB); ifc.ack <= 1'b1; rs <= 5; rdly <= $urandom_range(0, max_dly);
          end else begin rs <= 4; rdly <= d - 1; end
        end
        4: if (rdly == 0) begin
          ifc.C <= ref_gcd(ra, rb); ifc.ack <= 1'b1; rs <= 5; rdly <= $urandom_range(0, max_dly);
        end else rdly <= rdly - 1;
        5: if (!ifc.req) begin
          if (rdly == 0) begin ifc.ack <= 1'b0; ifc.C <= 16'd0; rs <= 0; end
          else rdly <= rdly - 1;
        end
        default: rs <= 0;
      endcase
    end
  end

  // Protocol monitor: req must not rise under ack, AB must hold while req is high.
  int          viol = 0;
  bit          req_seen = 0;
  logic        prev_req;
  logic [15:0] prev_ab;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_req = 1'b0;
      prev_ab  = 16'd0;
    end else begin
      if (ifc.req && !prev_req && ifc.ack) viol++;
      if (ifc.req && prev_req && ifc.AB !== prev_ab) viol++;
      if (ifc.req) req_seen = 1;
      prev_req = ifc.req;
      prev_ab  = ifc.AB;
    end
  end

  task automatic submit(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_a     = a;
    ifc.in_b     = b;
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (ifc.out_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = (ifc.out_valid === 1'b1);
  endtask

  task automatic consume();
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (ifc.req !== 1'b0 || ifc.AB !== 16'd0 || ifc.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_bus: req=%b AB=%0d out_valid=%b, want 0/0/0", ifc.req, ifc.AB, ifc.out_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (ifc.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready);
    end
    tests++;
    if (ifc.out_c !== 16'd0 || ifc.out_err !== 1'b0) begin
      fails++; $display("FAIL reset_result: out_c=%0d out_err=%b want 0/0", ifc.out_c, ifc.out_err);
    end
  endtask

  task automatic test_basic();
    bit ok;
    ab_q.delete();
    max_dly = 2;
    submit(16'd48, 16'd18);
    wait_done(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_done: out_valid got 0 want 1"); end
    tests++;
    if (ifc.out_c !== 16'd6 || ifc.out_err !== 1'b0) begin
      fails++; $display("FAIL basic_result: out_c=%0d err=%b want 6/0", ifc.out_c, ifc.out_err);
    end
    tests++;
    if (ab_q.size() != 2 || ab_q[0] !== 16'd48 || ab_q[1] !== 16'd18) begin
      fails++; $display("FAIL basic_ab_order: got %0d words want 48 then 18", ab_q.size());
    end
    consume();
  endtask

  task automatic test_zero();
    logic [15:0] za[3] = '{16'd0, 16'd0, 16'd9};
    logic [15:0] zb[3] = '{16'd5, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      req_seen = 0;
      submit(za[i], zb[i]);
      tests++;
      if (ifc.out_valid !== 1'b1 || ifc.out_c !== ref_gcd(za[i], zb[i]) || ifc.out_err !== 1'b0) begin
        fails++; $display("FAIL zero_result[%0d]: valid=%b out_c=%0d want 1/%0d", i, ifc.out_valid, ifc.out_c, ref_gcd(za[i], zb[i]));
      end
      consume();
      tests++;
      if (req_seen) begin fails++; $display("FAIL zero_no_req[%0d]: req seen 1 want 0", i); end
    end
  endtask

  task automatic test_hold();
    bit ok;
    bit stable = 1;
    submit(16'd7, 16'd7);
    wait_done(ok);
    for (int i = 0; i < 10; i++) begin
      if (ifc.out_valid !== 1'b1 || ifc.out_c !== 16'd7) stable = 0;
      @(negedge clk);
    end
    tests++;
    if (!ok || !stable) begin fails++; $display("FAIL hold_stable: ok=%b stable=%b want 1/1", ok, stable); end
    consume();
    tests++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      fails++; $display("FAIL hold_release: in_ready=%b out_valid=%b want 1/0", ifc.in_ready, ifc.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    stall_b = 1;
    submit(16'd100, 16'd75);
    while (!(ifc.req === 1'b1 && rs == 3) && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (n >= 200) begin fails++; $display("FAIL rmid_reach_send_b: timed out after %0d cycles", n); end
    pulse_reset();
    stall_b = 0;
    @(negedge clk);
    tests++;
    if (ifc.req !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_after: req=%b out_valid=%b in_ready=%b want 0/0/1", ifc.req, ifc.out_valid, ifc.in_ready);
    end
    ab_q.delete();
    submit(16'd35, 16'd21);
    wait_done(ok);
    tests++;
    if (!ok || ifc.out_c !== 16'd7) begin fails++; $display("FAIL rmid_new_job: out_c=%0d want 7", ifc.out_c); end
    consume();
  endtask

  task automatic test_ignore();
    bit ok;
    int n = 0;
    max_dly = 0;
    ab_q.delete();
    submit(16'd84, 16'd36);
    while (!(ifc.req === 1'b0 && ifc.ack === 1'b1 && rs == 2) && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (n >= 200) begin fails++; $display("FAIL ign_reach_rel_a: timed out after %0d cycles", n); end
    ifc.in_valid = 1'b1;
    ifc.in_a     = 16'd99;
    ifc.in_b     = 16'd99;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    wait_done(ok);
    tests++;
    if (!ok || ifc.out_c !== 16'd12 || ab_q.size() != 2 || ab_q[1] !== 16'd36) begin
      fails++; $display("FAIL ign_result: out_c=%0d words=%0d want 12 and 2 words", ifc.out_c, ab_q.size());
    end
    consume();
    repeat (3) @(negedge clk);
    tests++;
    if (ifc.out_valid !== 1'b0 || ifc.req !== 1'b0) begin
      fails++; $display("FAIL ign_no_job: out_valid=%b req=%b want 0/0", ifc.out_valid, ifc.req);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] a, b, g;
    for (int i = 0; i < 25; i++) begin
      g = 16'($urandom_range(1, 50));
      a = g * 16'($urandom_range(0, 400));
      b = g * 16'($urandom_range(0, 400));
      max_dly = $urandom_range(0, 3);
      ab_q.delete();
      submit(a, b);
      wait_done(ok);
      tests++;
      if (!ok || ifc.out_c !== ref_gcd(a, b) || ifc.out_err !== 1'b0) begin
        fails++; $display("FAIL rand_result[%0d]: a=%0d b=%0d out_c=%0d want %0d", i, a, b, ifc.out_c, ref_gcd(a, b));
      end
      tests++;
      if ((a != 0 && b != 0) ? (ab_q.size() != 2 || ab_q[0] !== a || ab_q[1] !== b) : (ab_q.size() != 0)) begin
        fails++; $display("FAIL rand_ab[%0d]: a=%0d b=%0d words=%0d", i, a, b, ab_q.size());
      end
      consume();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    never_ack = 1;
    submit(16'd12, 16'd8);
`ifdef GCD_DRV_TIMEOUT_EN
    while (ifc.req === 1'b1 && n < 100) begin n++; @(negedge clk); end
    tests++;
    if (n != 16) begin fails++; $display("FAIL tmo_req_cycles: got %0d want 16", n); end
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.out_err !== 1'b1 || ifc.out_c !== 16'd0) begin
      fails++; $display("FAIL tmo_result: valid=%b err=%b out_c=%0d want 1/1/0", ifc.out_valid, ifc.out_err, ifc.out_c);
    end
    consume();
`else
    while (n < 40) begin n++; @(negedge clk); end
    tests++;
    if (ifc.req !== 1'b1 || ifc.out_valid !== 1'b0) begin
      fails++; $display("FAIL no_tmo_wait: req=%b out_valid=%b want 1/0", ifc.req, ifc.out_valid);
    end
    pulse_reset();
    tests++;
    if (ifc.in_ready !== 1'b1 || ifc.req !== 1'b0) begin
      fails++; $display("FAIL no_tmo_abort: in_ready=%b req=%b want 1/0", ifc.in_ready, ifc.req);
    end
`endif
    never_ack = 0;
  endtask

  task automatic test_protocol();
    tests++;
    if (viol != 0) begin fails++; $display("FAIL protocol: %0d violations want 0", viol); end
  endtask

  initial begin
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_a      = 16'd0;
    ifc.in_b      = 16'd0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_hold();
    test_reset_mid();
    test_ignore();
    test_random();
    test_timeout();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_driver.md
GCD_DRIVER -- requirements
Module: gcd_driver

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, maximum cycles the driver waits for ack in any waiting state; used only when GCD_DRV_TIMEOUT_EN is defined.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  job request from the local client.
REQ-005 in_ready  output  1  driver can accept a job.
REQ-006 in_a  input  16  first operand, unsigned.
REQ-007 in_b  input  16  second operand, unsigned.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  client consumes the result.
REQ-010 out_c  output  16  GCD result.
REQ-011 out_err  output  1  result invalid because of a timeout.
REQ-012 req  output  1  4-phase request to the GCD unit.
REQ-013 ack  input  1  4-phase acknowledge from the GCD unit, synchronous to clk.
REQ-014 AB  output  16  operand bus to the GCD unit.
REQ-015 C  input  16  result bus from the GCD unit; valid only while ack=1 in the result phase.

Function
REQ-016 States: IDLE, SEND_A, REL_A, SEND_B, REL_B, DONE; req, AB, in_ready and out_valid SHALL be Moore outputs of state and registers.
REQ-017 IDLE: in_ready=1, req=0, AB=0; on in_valid=1, latch in_a/in_b into reg_a/reg_b.
REQ-018 If both latched operands are nonzero, IDLE -> SEND_A.
REQ-019 If either operand is zero, no handshake occurs: the result is the other operand (0 for 0,0), out_err=0, and the next state is DONE.
REQ-020 SEND_A: req=1, AB=reg_a; stay until ack=1, then -> REL_A.
REQ-021 REL_A: req=0, AB=reg_b; stay until ack=0, then -> SEND_B.
REQ-022 SEND_B: req=1, AB=reg_b held stable; stay until ack=1, then register C into the result register and -> REL_B.
REQ-023 REL_B: req=0, AB=reg_b; stay until ack=0, then -> DONE.
REQ-024 DONE: out_valid=1, out_c/out_err from registers and stable; on out_ready=1 -> IDLE; in_ready=0 until IDLE.
REQ-025 in_valid in any state other than IDLE is ignored, with no side effects.
REQ-026 An ack that arrives in the same cycle the state is entered SHALL be honoured; no minimum dwell time.
REQ-027 req SHALL never rise while ack=1, and AB SHALL not change while req=1.
REQ-028 Equal operands are a valid job; result = operand.
REQ-029 Only one job is outstanding; no buffering beyond reg_a, reg_b and the result register.

Reset
REQ-030 Reset asserted at any time SHALL force IDLE, req=0, AB=0, out_valid=0, out_c=0, out_err=0, in_ready=1 (after release), and clear all registers and the timeout counter.
REQ-031 Reset mid-handshake aborts the job with no result; the GCD unit SHALL be reset by the same signal.

Configuration
REQ-032 Macro GCD_DRV_TIMEOUT_EN defined: a counter clears on each state change and increments every cycle spent in SEND_A, REL_A, SEND_B or REL_B.
REQ-033 When the counter reaches TIMEOUT_CYCLES, the driver drops req, sets out_c=0 and out_err=1, and -> DONE.
REQ-034 Macro undefined: no counter is present, out_err is tied 0, and the waiting states wait indefinitely.

Verification
REQ-035 in_a=48, in_b=18 with a behavioural GCD responder -> AB=48 then 18 on the 4-phase handshake; out_valid with out_c=6, out_err=0.
REQ-036 in_a=0, in_b=5 -> req stays 0 throughout; out_valid the cycle after acceptance with out_c=5; in_a=0, in_b=0 -> out_c=0.
REQ-037 in_a=7, in_b=7 with out_ready held 0 for 10 cycles -> out_valid=1 and out_c=7 stable for all 10 cycles; IDLE the cycle after out_ready=1.
REQ-038 Reset pulse while in SEND_B -> next cycle req=0, out_valid=0, in_ready=1; a new job 35,21 then yields out_c=7.
REQ-039 GCD_DRV_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, responder never acks -> req drops after 16 cycles in SEND_A; out_valid=1, out_err=1, out_c=0.
REQ-040 in_valid pulsed during REL_A with in_a=99 -> ignored; the current job's result is unaffected.
